char_buffer_ctrl: RTL and testbench

CHAR_BUFFER_CTRL -- requirements
Module: char_buffer_ctrl

---
 rtl/char_buffer_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_char_buffer_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_ctrl.sv
// ============================================================================
// Module      : char_buffer_ctrl
// Description : Character-terminal buffer controller with scrolling row map,
//               line/screen clear engines and display-priority buffer port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module char_buffer_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 32,
    localparam int COL_W  = $clog2(COLS),
    localparam int ROW_W  = $clog2(ROWS),
    localparam int DEPTH  = COLS * ROWS,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              disp_req,
    input  logic [ROW_W-1:0]  disp_row,
    input  logic [COL_W-1:0]  disp_col,
    output logic              disp_gnt,
    input  logic              ch_valid,
    input  logic [7:0]        ch_data,
    output logic              ch_ready,
    output logic              buf_ce,
    output logic              buf_wre,
    output logic [ADDR_W-1:0] buf_ad,
    output logic [7:0]        buf_din,
    output logic              buf_reset,
    output logic [COL_W-1:0]  cur_col,
    output logic [ROW_W-1:0]  cur_row,
    output logic [ROW_W-1:0]  top_row
);

    localparam logic [7:0] c_BS    = 8'h08;
    localparam logic [7:0] c_LF    = 8'h0A;
    localparam logic [7:0] c_FF    = 8'h0C;
    localparam logic [7:0] c_CR    = 8'h0D;
    localparam logic [7:0] c_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        CLRLINE = 2'd2,
        CLRALL  = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [COL_W-1:0]    cur_col_q, cur_col_d;
    logic [ROW_W-1:0]    cur_row_q, cur_row_d;
    logic [ROW_W-1:0]    top_row_q, top_row_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                ready_q,   ready_d;

    logic                w_accept;
    logic                w_printable;
    logic                w_newline;
    logic                w_wr_cycle;
    logic [ADDR_W-1:0]   w_disp_addr;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [7:0]          w_wr_data;

    // Logical (row, col) to physical address; out-of-range inputs are clamped
    // so the buffer address never leaves 0..DEPTH-1.
    function automatic logic [ADDR_W-1:0] map_addr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] top
    );
        logic [ROW_W:0]   sum;
        logic [ROW_W-1:0] rc;
        logic [COL_W-1:0] cc;
        rc  = ({1'b0, row} >= (ROW_W+1)'(ROWS)) ? ROW_W'(ROWS-1) : row;
        cc  = (col >= COL_W'(COLS)) ? COL_W'(COLS-1) : col;
        sum = {1'b0, rc} + {1'b0, top};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end
        return ADDR_W'(sum[ROW_W-1:0]) * ADDR_W'(COLS) + ADDR_W'(cc);
    endfunction

    assign w_accept    = ch_valid & ready_q & (state_q == IDLE);
    assign w_printable = (ch_data >= 8'h20) && (ch_data <= 8'h7E);

    always_comb begin
        state_d   = state_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        top_row_d = top_row_q;
        clr_cnt_d = clr_cnt_q;
        wr_data_d = wr_data_q;
        w_newline = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_printable) begin
                        state_d   = WRITE;
                        wr_data_d = ch_data;
                    end else begin
                        case (ch_data)
                            c_CR: cur_col_d = '0;
                            c_BS: if (cur_col_q != '0) cur_col_d = cur_col_q - 1'b1;
                            c_LF: w_newline = 1'b1;
                            c_FF: begin
                                state_d   = CLRALL;
                                clr_cnt_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (!disp_req) begin
                    state_d = IDLE;
                    if (cur_col_q == COL_W'(COLS-1)) begin
                        cur_col_d = '0;
                        w_newline = 1'b1;
                    end else begin
                        cur_col_d = cur_col_q + 1'b1;
                    end
                end
            end
            CLRLINE: begin
                if (!disp_req) begin
                    if (clr_cnt_q == ADDR_W'(COLS-1)) begin
                        state_d = IDLE;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            CLRALL: begin
                if (!disp_req) begin
                    if (clr_cnt_q == ADDR_W'(DEPTH-1)) begin
                        state_d   = IDLE;
                        cur_col_d = '0;
                        cur_row_d = '0;
                        top_row_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // On the last row a newline scrolls: the old top row becomes the new
        // bottom row and must be blanked.
        if (w_newline) begin
            if (cur_row_q != ROW_W'(ROWS-1)) begin
                cur_row_d = cur_row_q + 1'b1;
            end else begin
                top_row_d = (top_row_q == ROW_W'(ROWS-1)) ? '0 : top_row_q + 1'b1;
                state_d   = CLRLINE;
                clr_cnt_d = '0;
            end
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cur_col_q <= '0;
            cur_row_q <= '0;
            top_row_q <= '0;
            clr_cnt_q <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            top_row_q <= top_row_d;
            clr_cnt_q <= clr_cnt_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        w_wr_addr = '0;
        w_wr_data = c_SPACE;
        case (state_q)
            WRITE: begin
                w_wr_addr = map_addr(cur_row_q, cur_col_q, top_row_q);
                w_wr_data = wr_data_q;
            end
            CLRLINE: w_wr_addr = map_addr(ROW_W'(ROWS-1), clr_cnt_q[COL_W-1:0], top_row_q);
            CLRALL:  w_wr_addr = clr_cnt_q;
            default: ;
        endcase
    end

    // The display always wins the port; a pending write simply waits.
    assign w_disp_addr = map_addr(disp_row, disp_col, top_row_q);
    assign disp_gnt    = resetn & disp_req;
    assign w_wr_cycle  = resetn & ~disp_req & (state_q != IDLE);
    assign buf_ce      = disp_gnt | w_wr_cycle;
    assign buf_wre     = w_wr_cycle;
    assign buf_ad      = disp_gnt ? w_disp_addr : (w_wr_cycle ? w_wr_addr : '0);
    assign buf_din     = w_wr_cycle ? w_wr_data : 8'h00;
    assign buf_reset   = ~resetn;

    assign ch_ready = ready_q;
    assign cur_col  = cur_col_q;
    assign cur_row  = cur_row_q;
    assign top_row  = top_row_q;

endmodule

`default_nettype wire

// File: tb/tb_char_buffer_ctrl.sv
// ============================================================================
// Module      : tb_char_buffer_ctrl
// Description : Randomized bench for char_buffer_ctrl against a terminal model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_char_buffer_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 32;
    localparam int DEPTH = COLS * ROWS;
    localparam int BOUND = 10000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        disp_req;
    logic [4:0]  disp_row;
    logic [6:0]  disp_col;
    logic        disp_gnt;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        buf_ce, buf_wre, buf_reset;
    logic [11:0] buf_ad;
    logic [7:0]  buf_din;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row, top_row;

    char_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .resetn(resetn),
        .disp_req(disp_req), .disp_row(disp_row), .disp_col(disp_col), .disp_gnt(disp_gnt),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .buf_ce(buf_ce), .buf_wre(buf_wre), .buf_ad(buf_ad), .buf_din(buf_din),
        .buf_reset(buf_reset), .cur_col(cur_col), .cur_row(cur_row), .top_row(top_row)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Terminal model: cursor, scroll offset and expected buffer contents.
    logic [7:0] m_mem [DEPTH];
    int m_col = 0, m_row = 0, m_top = 0;

    function automatic int m_map(input int r, input int c);
        return ((r + m_top) % ROWS) * COLS + c;
    endfunction

    function automatic int m_newline();
        if (m_row < ROWS - 1) begin
            m_row++;
            return 0;
        end
        m_top = (m_top + 1) % ROWS;
        for (int i = 0; i < COLS; i++) m_mem[((m_top + ROWS - 1) % ROWS) * COLS + i] = 8'h20;
        return COLS;
    endfunction

    function automatic int m_apply(input logic [7:0] c);
        int n = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            m_mem[m_map(m_row, m_col)] = c;
            n = 1;
            if (m_col == COLS - 1) begin
                m_col = 0;
                n += m_newline();
            end else begin
                m_col++;
            end
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (c == 8'h0A) begin
            n = m_newline();
        end else if (c == 8'h0C) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h20;
            m_col = 0; m_row = 0; m_top = 0;
            n = DEPTH;
        end
        return n;
    endfunction

    // Observed buffer writes and a shadow RAM built from them.
    logic [7:0] s_mem [DEPTH];
    int w_ad[$], w_dat[$], w_cyc[$];
    int cyc = 0;
    logic disp_held = 1'b0;
    logic rand_en   = 1'b0;
    int   hold_cnt  = 0;
    logic [4:0] hold_row = '0;
    logic [6:0] hold_col = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (buf_ce && buf_wre) begin
                check_eq("wr_ad_range", 32'(buf_ad < 12'(DEPTH)), 1);
                if (buf_ad < 12'(DEPTH)) s_mem[buf_ad] = buf_din;
                w_ad.push_back(int'(buf_ad));
                w_dat.push_back(int'(buf_din));
                w_cyc.push_back(cyc);
            end
            if (disp_req) begin
                check_eq("disp_gnt", 32'(disp_gnt), 1);
                check_eq("disp_ce", 32'(buf_ce), 1);
                check_eq("disp_no_wre", 32'(buf_wre), 0);
                if (ch_ready || disp_held)
                    check_eq("disp_addr", 32'(buf_ad), m_map(int'(disp_row), int'(disp_col)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (hold_cnt > 0) begin
            disp_req = 1'b1; disp_row = hold_row; disp_col = hold_col;
            disp_held = 1'b1; hold_cnt--;
        end else if (rand_en) begin
            disp_req  = ($urandom_range(0, 99) < 30);
            disp_row  = 5'($urandom_range(0, ROWS - 1));
            disp_col  = 7'($urandom_range(0, COLS - 1));
            disp_held = 1'b0;
        end else begin
            disp_req = 1'b0; disp_held = 1'b0;
        end
    endtask

    // Offer one character, wait for acceptance, then (unless no_wait) wait for
    // ready to return and compare write count, cursor and scroll with the model.
    task automatic send_char(input logic [7:0] c, input bit no_wait,
                             output int acc_cyc, output int lat);
        int n0, exp_n, k;
        logic acc;
        ch_valid = 1'b1; ch_data = c; acc = 1'b0; k = 0; lat = -1; acc_cyc = 0;
        while (!acc && k < BOUND) begin
            @(negedge clk); #1;
            acc = ch_ready; acc_cyc = cyc;
            tick(); k++;
        end
        ch_valid = 1'b0;
        if (!acc) begin
            check_eq("accept_timeout", 0, 1);
            return;
        end
        n0 = w_ad.size();
        exp_n = m_apply(c);
        if (no_wait) return;
        acc = 1'b0; k = 0; lat = 0;
        while (!acc && k < BOUND) begin
            @(negedge clk); #1;
            lat++; acc = ch_ready;
            tick(); k++;
        end
        if (!acc) check_eq("ready_timeout", 0, 1);
        check_eq("n_writes", w_ad.size() - n0, exp_n);
        check_eq("cur_col", 32'(cur_col), m_col);
        check_eq("cur_row", 32'(cur_row), m_row);
        check_eq("top_row", 32'(top_row), m_top);
    endtask

    logic [7:0] c_other [6] = '{8'h00, 8'h07, 8'h1B, 8'h7F, 8'h9A, 8'hFF};

    initial begin
        int ac, lt, n0, ok, r;
        logic [7:0] c;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; s_mem[i] = 8'h00; end
        resetn = 1'b0; ch_valid = 1'b0; ch_data = 8'h00;
        disp_req = 1'b1; disp_row = 5'd3; disp_col = 7'd7;

        // Reset state, including display gating while in reset
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ch_ready), 0);
        check_eq("rst_ce", 32'(buf_ce), 0);
        check_eq("rst_wre", 32'(buf_wre), 0);
        check_eq("rst_gnt", 32'(disp_gnt), 0);
        check_eq("rst_ad", 32'(buf_ad), 0);
        check_eq("rst_din", 32'(buf_din), 0);
        check_eq("rst_bufreset", 32'(buf_reset), 1);
        check_eq("rst_cursor", {20'd0, cur_col, cur_row}, 0);
        check_eq("rst_top", 32'(top_row), 0);
        resetn = 1'b1; disp_req = 1'b0;
        tick();
        check_eq("ready_after_rst", 32'(ch_ready), 1);
        check_eq("bufreset_low", 32'(buf_reset), 0);

        // 'A' uncontested: write at accept+1, ready at accept+2
        n0 = w_ad.size();
        send_char(8'h41, 1'b0, ac, lt);
        check_eq("A_lat", lt, 2);
        if (w_ad.size() > n0) begin
            check_eq("A_ad", w_ad[n0], 0);
            check_eq("A_din", w_dat[n0], 8'h41);
            check_eq("A_cyc", w_cyc[n0], ac + 1);
        end else check_eq("A_written", 0, 1);

        // 'B' held off by 5 display cycles
        n0 = w_ad.size();
        hold_cnt = 5; hold_row = 5'd3; hold_col = 7'd7;
        send_char(8'h42, 1'b0, ac, lt);
        check_eq("B_lat", lt, 7);
        if (w_ad.size() > n0) begin
            check_eq("B_ad", w_ad[n0], 1);
            check_eq("B_din", w_dat[n0], 8'h42);
            check_eq("B_cyc", w_cyc[n0], ac + 6);
        end else check_eq("B_written", 0, 1);

        // Reach (31,79) then print 'Z' to force a scroll
        for (int i = 0; i < ROWS - 1; i++) send_char(8'h0A, 1'b0, ac, lt);
        send_char(8'h0D, 1'b0, ac, lt);
        for (int i = 0; i < COLS - 1; i++) send_char(8'(8'h61 + i % 26), 1'b0, ac, lt);
        check_eq("pre_Z_col", 32'(cur_col), 79);
        n0 = w_ad.size();
        send_char(8'h5A, 1'b0, ac, lt);
        check_eq("Z_lat", lt, 82);
        if (w_ad.size() >= n0 + 81) begin
            check_eq("Z_ad", w_ad[n0], 2559);
            check_eq("Z_din", w_dat[n0], 8'h5A);
            ok = 0;
            for (int i = 0; i < COLS; i++)
                if (w_ad[n0 + 1 + i] == i && w_dat[n0 + 1 + i] == 8'h20) ok++;
            check_eq("clrline_seq", ok, COLS);
        end else check_eq("Z_writes", w_ad.size() - n0, 81);
        check_eq("Z_top", 32'(top_row), 1);
        check_eq("Z_cursor", {20'd0, cur_col, cur_row}, {20'd0, 7'd0, 5'd31});

        // Display mapping with top_row = 1
        hold_cnt = 1; hold_row = 5'd0; hold_col = 7'd5;
        tick(); @(negedge clk); #1;
        check_eq("disp_0_5", 32'(buf_ad), 85);
        hold_cnt = 1; hold_row = 5'd31; hold_col = 7'd5;
        tick(); @(negedge clk); #1;
        check_eq("disp_31_5", 32'(buf_ad), 5);
        tick();

        // Form feed: full clear, ready low throughout
        n0 = w_ad.size();
        send_char(8'h0C, 1'b0, ac, lt);
        check_eq("FF_lat", lt, DEPTH + 1);
        if (w_ad.size() >= n0 + DEPTH) begin
            ok = 0;
            for (int i = 0; i < DEPTH; i++)
                if (w_ad[n0 + i] == i && w_dat[n0 + i] == 8'h20) ok++;
            check_eq("clrall_seq", ok, DEPTH);
        end
        check_eq("FF_top", 32'(top_row), 0);

        // BS at col 0, CR at col 40, BEL discarded
        send_char(8'h08, 1'b0, ac, lt);
        check_eq("BS_col0", 32'(cur_col), 0);
        for (int i = 0; i < 40; i++) send_char(8'h2E, 1'b0, ac, lt);
        check_eq("col40", 32'(cur_col), 40);
        send_char(8'h0D, 1'b0, ac, lt);
        check_eq("CR_col", 32'(cur_col), 0);
        for (int i = 0; i < 5; i++) send_char(8'h2B, 1'b0, ac, lt);
        n0 = w_ad.size();
        send_char(8'h07, 1'b0, ac, lt);
        check_eq("BEL_col", 32'(cur_col), 5);
        check_eq("BEL_nowrite", w_ad.size() - n0, 0);
        check_eq("BEL_lat", lt, 1);

        // Random traffic with random display contention
        rand_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      c = 8'($urandom_range(32, 126));
            else if (r < 75) c = 8'h0A;
            else if (r < 82) c = 8'h0D;
            else if (r < 89) c = 8'h08;
            else if (r < 90) c = 8'h0C;
            else             c = c_other[$urandom_range(0, 5)];
            send_char(c, 1'b0, ac, lt);
        end
        rand_en = 1'b0;
        tick();
        ok = 0;
        for (int i = 0; i < DEPTH; i++) if (s_mem[i] !== m_mem[i]) ok++;
        check_eq("mem_mismatches", ok, 0);

        // Asynchronous reset in the middle of a full clear
        send_char(8'h0C, 1'b0, ac, lt);
        for (int i = 0; i < 3; i++) send_char(8'h70, 1'b0, ac, lt);
        n0 = w_ad.size();
        send_char(8'h0C, 1'b1, ac, lt);
        repeat (100) tick();
        check_eq("midclr_col", 32'(cur_col), 3);
        check_eq("midclr_ready", 32'(ch_ready), 0);
        disp_req = 1'b1; disp_row = 5'd2; disp_col = 7'd9;
        #2;
        resetn = 1'b0;
        #1;
        check_eq("arst_col", 32'(cur_col), 0);
        check_eq("arst_ce", 32'(buf_ce), 0);
        check_eq("arst_gnt", 32'(disp_gnt), 0);
        check_eq("arst_ready", 32'(ch_ready), 0);
        check_eq("partial_clear", 32'((w_ad.size() - n0) > 0 && (w_ad.size() - n0) < DEPTH), 1);
        @(posedge clk); #1;
        resetn = 1'b1; disp_req = 1'b0;
        @(posedge clk); #1;
        check_eq("arst_ready_after", 32'(ch_ready), 1);
        check_eq("arst_wre_idle", 32'(buf_wre), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
